// File: rtl/biriscv_alu_arbiter.sv
// Round-robin arbiter that time-shares a single biriscv_alu between two requesters.
// Each accepted operation is returned through a per-port registered result slot with valid/ready handshake.

module biriscv_alu (
  input  logic [3:0]  alu_op_i,
  input  logic [31:0] alu_a_i,
  input  logic [31:0] alu_b_i,
  output logic [31:0] alu_p_o
);

  localparam logic [3:0] ALU_NONE             = 4'b0000;
  localparam logic [3:0] ALU_SHIFTL           = 4'b0001;
  localparam logic [3:0] ALU_SHIFTR           = 4'b0010;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'b0011;
  localparam logic [3:0] ALU_ADD              = 4'b0100;
  localparam logic [3:0] ALU_SUB              = 4'b0110;
  localparam logic [3:0] ALU_AND              = 4'b0111;
  localparam logic [3:0] ALU_OR               = 4'b1000;
  localparam logic [3:0] ALU_XOR              = 4'b1001;
  localparam logic [3:0] ALU_LESS_THAN        = 4'b1010;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'b1011;

  logic [31:0] w_result;
  logic [4:0]  w_shamt;

  assign w_shamt = alu_b_i[4:0];

  always_comb begin
    // NOTE: default assignment first so every path drives w_result and no latch is inferred.
    w_result = alu_a_i;
    case (alu_op_i)
      ALU_NONE:             w_result = alu_a_i;
      ALU_SHIFTL:           w_result = alu_a_i << w_shamt;
      ALU_SHIFTR:           w_result = alu_a_i >> w_shamt;
      ALU_SHIFTR_ARITH:     w_result = $unsigned($signed(alu_a_i) >>> w_shamt);
      ALU_ADD:              w_result = alu_a_i + alu_b_i;
      ALU_SUB:              w_result = alu_a_i - alu_b_i;
      ALU_AND:              w_result = alu_a_i & alu_b_i;
      ALU_OR:               w_result = alu_a_i | alu_b_i;
      ALU_XOR:              w_result = alu_a_i ^ alu_b_i;
      ALU_LESS_THAN:        w_result = {31'b0, (alu_a_i < alu_b_i)};
      ALU_LESS_THAN_SIGNED: w_result = {31'b0, ($signed(alu_a_i) < $signed(alu_b_i))};
      default:              w_result = alu_a_i;
    endcase
  end

  assign alu_p_o = w_result;

endmodule

module biriscv_alu_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,

  input  logic             req0_valid_i,
  input  logic [3:0]       req0_op_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             req0_accept_o,

  input  logic             req1_valid_i,
  input  logic [3:0]       req1_op_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             req1_accept_o,

  output logic             res0_valid_o,
  output logic [31:0]      res0_value_o,
  output logic [TAG_W-1:0] res0_tag_o,
  input  logic             res0_ready_i,

  output logic             res1_valid_o,
  output logic [31:0]      res1_value_o,
  output logic [TAG_W-1:0] res1_tag_o,
  input  logic             res1_ready_i,

  output logic [CNT_W-1:0] contention_o
);

  localparam logic [3:0] ALU_NOP = 4'b0000;

  logic             r_last_grant;
  logic             r_res0_valid;
  logic [31:0]      r_res0_value;
  logic [TAG_W-1:0] r_res0_tag;
  logic             r_res1_valid;
  logic [31:0]      r_res1_value;
  logic [TAG_W-1:0] r_res1_tag;
  logic [CNT_W-1:0] r_contention;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;
  logic [3:0]       w_alu_op;
  logic [31:0]      w_alu_a;
  logic [31:0]      w_alu_b;
  logic [31:0]      w_alu_result;
  logic [TAG_W-1:0] w_grant_tag;
  logic             w_refused;

  // A slot can take a new result if it is empty or draining this same cycle.
  assign w_elig0 = req0_valid_i && (!r_res0_valid || res0_ready_i) && !flush_i && !rst_i;
  assign w_elig1 = req1_valid_i && (!r_res1_valid || res1_ready_i) && !flush_i && !rst_i;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_elig0 && w_elig1) begin
      w_grant0 = r_last_grant;
      w_grant1 = !r_last_grant;
    end else begin
      w_grant0 = w_elig0;
      w_grant1 = w_elig1;
    end
  end

  assign req0_accept_o = w_grant0;
  assign req1_accept_o = w_grant1;

  // Idle cycles present port 0's operands with a no-op to keep the datapath quiet.
  assign w_alu_op    = w_grant1 ? req1_op_i : (w_grant0 ? req0_op_i : ALU_NOP);
  assign w_alu_a     = w_grant1 ? req1_a_i  : req0_a_i;
  assign w_alu_b     = w_grant1 ? req1_b_i  : req0_b_i;
  assign w_grant_tag = w_grant1 ? req1_tag_i : req0_tag_i;

  biriscv_alu u_alu (
    .alu_op_i (w_alu_op),
    .alu_a_i  (w_alu_a),
    .alu_b_i  (w_alu_b),
    .alu_p_o  (w_alu_result)
  );

  assign w_refused = (req0_valid_i && !w_grant0) || (req1_valid_i && !w_grant1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_res0_valid <= 1'b0;
      r_res0_value <= '0;
      r_res0_tag   <= '0;
    end else if (flush_i) begin
      r_res0_valid <= 1'b0;
    end else if (w_grant0) begin
      r_res0_valid <= 1'b1;
      r_res0_value <= w_alu_result;
      r_res0_tag   <= w_grant_tag;
    end else if (r_res0_valid && res0_ready_i) begin
      r_res0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_res1_valid <= 1'b0;
      r_res1_value <= '0;
      r_res1_tag   <= '0;
    end else if (flush_i) begin
      r_res1_valid <= 1'b0;
    end else if (w_grant1) begin
      r_res1_valid <= 1'b1;
      r_res1_value <= w_alu_result;
      r_res1_tag   <= w_grant_tag;
    end else if (r_res1_valid && res1_ready_i) begin
      r_res1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_contention <= '0;
    end else if (w_refused && (r_contention != {CNT_W{1'b1}})) begin
      r_contention <= r_contention + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign res0_valid_o = r_res0_valid;
  assign res0_value_o = r_res0_value;
  assign res0_tag_o   = r_res0_tag;
  assign res1_valid_o = r_res1_valid;
  assign res1_value_o = r_res1_value;
  assign res1_tag_o   = r_res1_tag;
  assign contention_o = r_contention;

endmodule

// File: tb/tb_biriscv_alu_arbiter.sv
// Directed bench for biriscv_alu_arbiter: arbitration order, latency, backpressure,
// flush, counter saturation (CNT_W=4) and asynchronous reset.

module tb_biriscv_alu_arbiter;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0011;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             req0_valid, req1_valid;
  logic [3:0]       req0_op, req1_op;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             req0_accept, req1_accept;
  logic             res0_valid, res1_valid;
  logic [31:0]      res0_value, res1_value;
  logic [TAG_W-1:0] res0_tag, res1_tag;
  logic             res0_ready, res1_ready;
  logic [CNT_W-1:0] contention;

  int n_cmp = 0;
  int n_err = 0;

  biriscv_alu_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .req0_valid_i  (req0_valid),
    .req0_op_i     (req0_op),
    .req0_a_i      (req0_a),
    .req0_b_i      (req0_b),
    .req0_tag_i    (req0_tag),
    .req0_accept_o (req0_accept),
    .req1_valid_i  (req1_valid),
    .req1_op_i     (req1_op),
    .req1_a_i      (req1_a),
    .req1_b_i      (req1_b),
    .req1_tag_i    (req1_tag),
    .req1_accept_o (req1_accept),
    .res0_valid_o  (res0_valid),
    .res0_value_o  (res0_value),
    .res0_tag_o    (res0_tag),
    .res0_ready_i  (res0_ready),
    .res1_valid_o  (res1_valid),
    .res1_value_o  (res1_value),
    .res1_tag_o    (res1_tag),
    .res1_ready_i  (res1_ready),
    .contention_o  (contention)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    req0_valid = 1'b0; req0_op = 4'h0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = 4'h0; req1_a = '0; req1_b = '0; req1_tag = '0;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    req0_valid = 1'b1;
    #3;
    check("rst_res0_valid", 32'(res0_valid), 32'd0);
    check("rst_res0_value", res0_value, 32'd0);
    check("rst_res0_tag", 32'(res0_tag), 32'd0);
    check("rst_res1_valid", 32'(res1_valid), 32'd0);
    check("rst_contention", 32'(contention), 32'd0);
    check("rst_no_accept0", 32'(req0_accept), 32'd0);
    req0_valid = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Single request on port 0: overflowing add, one-cycle latency.
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_tag = 4'd3;
    #1;
    check("single_accept0", 32'(req0_accept), 32'd1);
    check("single_accept1", 32'(req1_accept), 32'd0);
    step();
    req0_valid = 1'b0;
    check("single_res0_valid", 32'(res0_valid), 32'd1);
    check("single_res0_value", res0_value, 32'h8000_0000);
    check("single_res0_tag", 32'(res0_tag), 32'd3);
    check("single_res1_valid", 32'(res1_valid), 32'd0);
    check("single_contention", 32'(contention), 32'd0);

    // Both ports always requesting: grants alternate starting with port 0.
    do_reset();
    req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_op = OP_SRA; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_tag = 4'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_accept0_%0d", k), 32'(req0_accept), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_accept1_%0d", k), 32'(req1_accept), (k % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check($sformatf("rr_contention_%0d", k), 32'(contention), 32'(k + 1));
      if (k == 0) begin
        check("rr_res0_valid", 32'(res0_valid), 32'd1);
        check("rr_res0_value", res0_value, 32'hFFFF_FFFE);
        check("rr_res0_tag", 32'(res0_tag), 32'd1);
      end
      if (k == 1) begin
        check("rr_res1_valid", 32'(res1_valid), 32'd1);
        check("rr_res1_value", res1_value, 32'hF800_0000);
        check("rr_res1_tag", 32'(res1_tag), 32'd2);
        check("rr_res0_drained", 32'(res0_valid), 32'd0);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure on port 0, then same-cycle drain and refill.
    do_reset();
    res0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd2; req0_tag = 4'd5;
    #1;
    check("bp_first_accept", 32'(req0_accept), 32'd1);
    step();
    req0_a = 32'd10; req0_b = 32'd20; req0_tag = 4'd6;
    #1;
    check("bp_blocked_accept", 32'(req0_accept), 32'd0);
    step();
    check("bp_hold_valid", 32'(res0_valid), 32'd1);
    check("bp_hold_value", res0_value, 32'd3);
    check("bp_hold_tag", 32'(res0_tag), 32'd5);
    check("bp_contention", 32'(contention), 32'd1);
    res0_ready = 1'b1;
    #1;
    check("bp_refill_accept", 32'(req0_accept), 32'd1);
    step();
    req0_valid = 1'b0;
    check("bp_refill_valid", 32'(res0_valid), 32'd1);
    check("bp_refill_value", res0_value, 32'd30);
    check("bp_refill_tag", 32'(res0_tag), 32'd6);
    check("bp_refill_contention", 32'(contention), 32'd1);

    // Flush with both slots full and both requests pending.
    do_reset();
    res0_ready = 1'b0; res1_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd2; req1_b = 32'd2; req1_tag = 4'd2;
    #1;
    check("fl_accept0", 32'(req0_accept), 32'd1);
    step();
    #1;
    check("fl_accept1", 32'(req1_accept), 32'd1);
    check("fl_blocked0", 32'(req0_accept), 32'd0);
    step();
    check("fl_full0", 32'(res0_valid), 32'd1);
    check("fl_full1", 32'(res1_valid), 32'd1);
    check("fl_res1_value", res1_value, 32'd4);
    check("fl_pre_contention", 32'(contention), 32'd2);
    flush = 1'b1;
    #1;
    check("fl_no_accept0", 32'(req0_accept), 32'd0);
    check("fl_no_accept1", 32'(req1_accept), 32'd0);
    step();
    flush = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    res0_ready = 1'b1; res1_ready = 1'b1;
    check("fl_res0_cleared", 32'(res0_valid), 32'd0);
    check("fl_res1_cleared", 32'(res1_valid), 32'd0);
    check("fl_contention", 32'(contention), 32'd3);

    // Port 1 blocked for 20 cycles: 4-bit counter saturates at 0xF.
    do_reset();
    res1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd0; req1_b = 32'd0; req1_tag = 4'd9;
    step();
    check("sat_start", 32'(contention), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) check("sat_14", 32'(contention), 32'd14);
    end
    check("sat_hold", 32'(contention), 32'hF);
    check("sat_accept1", 32'(req1_accept), 32'd0);
    req1_valid = 1'b0;
    res1_ready = 1'b1;

    // Asynchronous reset between edges, then first conflict goes to port 0.
    do_reset();
    res0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd8; req0_b = 32'd8; req0_tag = 4'd7;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd1; req1_b = 32'd1; req1_tag = 4'd4;
    step();
    step();
    check("ar_pre_res0", 32'(res0_valid), 32'd1);
    check("ar_pre_contention", 32'(contention), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_res0_valid", 32'(res0_valid), 32'd0);
    check("ar_res0_value", res0_value, 32'd0);
    check("ar_res1_valid", 32'(res1_valid), 32'd0);
    check("ar_contention", 32'(contention), 32'd0);
    check("ar_no_accept0", 32'(req0_accept), 32'd0);
    check("ar_no_accept1", 32'(req1_accept), 32'd0);
    #2;
    rst = 1'b0;
    res0_ready = 1'b1;
    #1;
    check("ar_first_accept0", 32'(req0_accept), 32'd1);
    check("ar_first_accept1", 32'(req1_accept), 32'd0);
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/biriscv_alu_arbiter.md
Name: biriscv_alu_arbiter

Overview:
- Shares one biriscv_alu instance between two requesters, e.g. a secondary issue slot and a multi-cycle helper unit, so only one physical ALU is built.
- Arbitrates round-robin, one ALU operation per cycle.
- Registers each result into a per-port output slot with valid/ready backpressure.
- Provides a flush and a saturating contention counter for performance monitoring.

Parameters:
- TAG_W, 4, width of the opaque requester tag carried with each operation.
- CNT_W, 16, width of the contention counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- flush_i  input  1  drop all pending results; block all grants this cycle.
- req0_valid_i  input  1  port 0 request valid.
- req0_op_i  input  4  port 0 ALU opcode (`ALU_* encoding).
- req0_a_i  input  32  port 0 operand A.
- req0_b_i  input  32  port 0 operand B.
- req0_tag_i  input  TAG_W  port 0 tag.
- req0_accept_o  output  1  port 0 request accepted this cycle.
- req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_tag_i, req1_accept_o: same as port 0, for port 1.
- res0_valid_o  output  1  port 0 result slot full.
- res0_value_o  output  32  port 0 result.
- res0_tag_o  output  TAG_W  tag of port 0 result.
- res0_ready_i  input  1  port 0 consumer takes result.
- res1_valid_o, res1_value_o, res1_tag_o, res1_ready_i: same as port 0, for port 1.
- contention_o  output  CNT_W  count of cycles with a valid request not accepted.

Behaviour:
- Reset (async, rst_i=1):
  - res*_valid_o=0, res*_value_o=0, res*_tag_o=0.
  - contention_o=0.
  - last_grant=1, so port 0 wins the first conflict.
- Eligibility: port p is eligible when req_valid && (!res_valid || res_ready) && !flush_i.
- Grant:
  - Neither eligible: no grant; last_grant holds.
  - One eligible: grant it.
  - Both eligible: grant the port != last_grant.
  - last_grant updates to the granted port only on a grant.
- reqp_accept_o = grant to p; it is combinational from the current inputs and state.
- ALU inputs:
  - Muxed from the granted port.
  - When there is no grant, drive port 0's operands with op forced to 4'b0000 (no-op) to minimise toggling.
- Latency: request accepted in cycle N -> res_valid=1 with value and tag in cycle N+1. Full throughput: one result per cycle total.
- Result slot p per cycle, in priority order:
  1. flush_i -> valid cleared; value/tag don't-care.
  2. Grant to p -> load ALU result and tag, valid=1. This covers a same-cycle drain and refill.
  3. res_valid && res_ready -> valid=0.
  4. Otherwise hold. Value and tag are stable while valid=1 && !ready.
- res_ready_i while valid=0 is ignored.
- Contention counter:
  - Increments by 1 for each cycle in which at least one req*_valid_i=1 without its accept; a cycle with both ports refused still counts 1.
  - Flush cycles count when requests are pending.
  - Saturates at all-ones and does not wrap.
- Reset mid-operation: pending results are lost; no accept is asserted while rst_i=1.
- Operands are sampled only in the grant cycle; requesters must hold req* stable until accepted.
- Arithmetic is the ALU's 32-bit behaviour; shift amount is b[4:0]; unsupported opcodes pass A through.

Test Plan:
- Single port 0: `ALU_ADD, a=0x7FFFFFFF, b=1, tag=3 -> accept0 same cycle; next cycle res0_valid=1, value=0x80000000, tag=3; port 1 idle.
- Both ports valid every cycle, slots always ready (op0 `ALU_SUB 5-7, op1 `ALU_SHIFTR_ARITH 0x80000000>>4):
  - first grant goes to port 0, then grants alternate 0,1,0,1;
  - res0=0xFFFFFFFE, res1=0xF8000000;
  - contention_o +1 per cycle.
- Backpressure: res0_ready=0 with res0 full and a new port 0 request pending -> accept0=0 and res0 value/tag held; raise ready -> same-cycle drain and refill, valid stays 1, new value appears next cycle.
- Flush: both slots full, flush_i=1 with both requests valid -> no accepts; both res_valid=0 next cycle; contention increments once.
- Saturation: CNT_W=4, port 1 blocked for 20 cycles -> contention_o reaches 0xF and holds.
- Async reset asserted mid-stream between clock edges -> outputs clear immediately; after release the first conflict is granted to port 0.
